// File: rtl/inst_fetch_resp.sv
// Instruction-pair fetch response unit: two in-order bus reads per fetch, flush drain.
// Optional IFR_LINE_BUF_EN keeps a one-entry tag of the last completed aligned fetch.
module inst_fetch_resp (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        pcn,
   input  logic        flush,
   output logic [31:0] if_inst,
   output logic [31:0] if_inst_2,
   output logic        inst_valid,
   output logic        delay_hard,
   output logic        IADEE,
   output logic        ireq,
   output logic [31:0] iaddr,
   input  logic        iaddr_ok,
   input  logic [31:0] irdata,
   input  logic        idata_ok
);

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      REQ1,
      WAIT,
      DONE,
      DRAIN
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] fetch_pc;
   logic [31:0] word0;
   logic        got1;
   logic [1:0]  cnt;
   logic [1:0]  cnt_n;
   logic [31:0] phys;
   logic        aligned;
   logic        accept;
   logic        resp;
   logic        ld_pc;
   logic        ld_w0;
   logic        ld_pair;
   logic        ld_err;
   logic        unused_pc_bits;

`ifdef IFR_LINE_BUF_EN
   logic [31:0] tag;
   logic        tag_v;
   logic [31:0] buf0;
   logic [31:0] buf1;
   logic        hit;
   logic        ld_hit;

   assign hit = tag_v && (tag == pc);
`endif

   assign aligned = (pc[1:0] == 2'b00);
   assign phys    = {3'b000, fetch_pc[28:2], 2'b00};
   assign accept  = ireq && iaddr_ok;
   // a response with nothing outstanding is stale (e.g. from before reset)
   assign resp    = idata_ok && (cnt != 2'd0);

   assign unused_pc_bits = ^{fetch_pc[31:29], fetch_pc[1:0]};

   always_comb begin
      cnt_n = cnt;
      if (accept && !resp && cnt != 2'd2) begin
         cnt_n = cnt + 2'd1;
      end else if (resp && !accept) begin
         cnt_n = cnt - 2'd1;
      end
   end

   always_comb begin
      state_n    = state;
      ireq       = 1'b0;
      iaddr      = 32'd0;
      delay_hard = 1'b0;
      inst_valid = 1'b0;
      ld_pc      = 1'b0;
      ld_w0      = 1'b0;
      ld_pair    = 1'b0;
      ld_err     = 1'b0;
`ifdef IFR_LINE_BUF_EN
      ld_hit     = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (pcn && !flush) begin
               if (!aligned) begin
                  ld_err  = 1'b1;
                  state_n = DONE;
`ifdef IFR_LINE_BUF_EN
               end else if (hit) begin
                  ld_hit  = 1'b1;
                  state_n = DONE;
`endif
               end else begin
                  ld_pc      = 1'b1;
                  delay_hard = 1'b1;
                  state_n    = REQ0;
               end
            end
         end
         REQ0: begin
            delay_hard = 1'b1;
            if (flush) begin
               state_n = IDLE;
            end else begin
               ireq  = 1'b1;
               iaddr = phys;
               if (iaddr_ok) begin
                  state_n = REQ1;
               end
            end
         end
         REQ1: begin
            delay_hard = 1'b1;
            if (flush) begin
               state_n = DRAIN;
            end else begin
               ireq  = 1'b1;
               iaddr = phys + 32'd4;
               ld_w0 = resp;
               if (iaddr_ok) begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            delay_hard = 1'b1;
            if (flush) begin
               state_n = DRAIN;
            end else if (resp) begin
               if (got1) begin
                  ld_pair = 1'b1;
                  state_n = DONE;
               end else begin
                  ld_w0 = 1'b1;
               end
            end
         end
         DRAIN: begin
            delay_hard = 1'b1;
            if (cnt == 2'd0 || (cnt == 2'd1 && resp)) begin
               state_n = IDLE;
            end
         end
         DONE: begin
            inst_valid = !flush;
            state_n    = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (reset) begin
         ireq       = 1'b0;
         iaddr      = 32'd0;
         delay_hard = 1'b0;
         inst_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         fetch_pc  <= 32'hbfc0_0000;
         word0     <= 32'd0;
         got1      <= 1'b0;
         if_inst   <= 32'd0;
         if_inst_2 <= 32'd0;
         IADEE     <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (ld_pc) begin
            fetch_pc <= pc;
            got1     <= 1'b0;
         end
         if (ld_w0) begin
            word0 <= irdata;
            got1  <= 1'b1;
         end
         if (ld_err) begin
            if_inst   <= 32'd0;
            if_inst_2 <= 32'd0;
            IADEE     <= 1'b1;
         end
         if (ld_pair) begin
            if_inst   <= word0;
            if_inst_2 <= irdata;
            IADEE     <= 1'b0;
         end
`ifdef IFR_LINE_BUF_EN
         if (ld_hit) begin
            if_inst   <= buf0;
            if_inst_2 <= buf1;
            IADEE     <= 1'b0;
         end
`endif
      end
   end

`ifdef IFR_LINE_BUF_EN
   // the pair is buffered separately: if_inst may since hold an error result
   always_ff @(posedge clk) begin
      if (reset) begin
         tag   <= 32'd0;
         tag_v <= 1'b0;
         buf0  <= 32'd0;
         buf1  <= 32'd0;
      end else if (flush) begin
         tag_v <= 1'b0;
      end else if (ld_pair) begin
         tag   <= fetch_pc;
         tag_v <= 1'b1;
         buf0  <= word0;
         buf1  <= irdata;
      end
   end
`endif

endmodule
